// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-port ALU arbiter: function codes, sequencer
// states and requester ids.
package alu_arb_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_NOR = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;
    localparam logic [2:0] ALU_NE  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU shared by both arbiter ports; zero_flag reports an
// all-zero result.
module ALU
    import alu_arb_pkg::*;
#(
    parameter int size = 32
) (
    input  logic [2:0]      func,
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    output logic [size-1:0] out,
    output logic            zero_flag
);

    // Add/sub wrap; slt is an unsigned compare; ne returns 1 for a != b.
    always_comb begin
        out = '0;
        case (func)
            ALU_ADD: out = a + b;
            ALU_SUB: out = a - b;
            ALU_AND: out = a & b;
            ALU_OR:  out = a | b;
            ALU_NOR: out = ~(a | b);
            ALU_XOR: out = a ^ b;
            ALU_SLT: out = {{(size-1){1'b0}}, (a < b)};
            ALU_NE:  out = {{(size-1){1'b0}}, (a != b)};
            default: out = '0;
        endcase
    end

    assign zero_flag = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// sequenced IDLE -> EXEC -> RESP with a held result until the owner accepts it.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p0_req_valid,
    output logic            p0_req_ready,
    input  logic [2:0]      p0_func,
    input  logic [SIZE-1:0] p0_a,
    input  logic [SIZE-1:0] p0_b,
    output logic            p0_resp_valid,
    input  logic            p0_resp_ready,
    output logic [SIZE-1:0] p0_result,
    output logic            p0_zero,
    input  logic            p1_req_valid,
    output logic            p1_req_ready,
    input  logic [2:0]      p1_func,
    input  logic [SIZE-1:0] p1_a,
    input  logic [SIZE-1:0] p1_b,
    output logic            p1_resp_valid,
    input  logic            p1_resp_ready,
    output logic [SIZE-1:0] p1_result,
    output logic            p1_zero,
    output logic            busy
);

    arb_state_t      state_q, state_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic [2:0]      func_q, func_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            grant_any;
    logic            grant_port;
    logic            owner_resp_ready;
    logic [SIZE-1:0] alu_out;
    logic            alu_zero;

    ALU #(.size(SIZE)) u_alu (
        .func      (func_q),
        .a         (a_q),
        .b         (b_q),
        .out       (alu_out),
        .zero_flag (alu_zero)
    );

    // The prio port wins only under contention; a lone requester always wins.
    always_comb begin
        grant_any  = p0_req_valid | p1_req_valid;
        grant_port = PORT0;
        if (p0_req_valid && p1_req_valid) begin
            grant_port = prio_q;
        end else if (p1_req_valid) begin
            grant_port = PORT1;
        end
        owner_resp_ready = (owner_q == PORT1) ? p1_resp_ready : p0_resp_ready;
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        func_d   = func_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    owner_d = grant_port;
                    func_d  = (grant_port == PORT1) ? p1_func : p0_func;
                    a_d     = (grant_port == PORT1) ? p1_a : p0_a;
                    b_d     = (grant_port == PORT1) ? p1_b : p0_b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_resp_ready) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= PORT0;
            owner_q  <= PORT0;
            func_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            func_q   <= func_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Ready is gated by rst_n so a requester cannot see a grant while reset is held.
    assign p0_req_ready  = rst_n && (state_q == IDLE) && grant_any && (grant_port == PORT0);
    assign p1_req_ready  = rst_n && (state_q == IDLE) && grant_any && (grant_port == PORT1);
    assign p0_resp_valid = (state_q == RESP) && (owner_q == PORT0);
    assign p1_resp_valid = (state_q == RESP) && (owner_q == PORT1);
    assign busy          = (state_q != IDLE);
    assign p0_result     = result_q;
    assign p1_result     = result_q;
    assign p0_zero       = zero_q;
    assign p1_zero       = zero_q;

endmodule
